// File: rtl/vga_comp_pkg.sv
// Shared types and timing-polarity constants for the VGA layer compositor.
package vga_comp_pkg;

   localparam int unsigned COLOR_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } phase_t;

   typedef struct packed {
      logic [COLOR_W_DEF-1:0] r;
      logic [COLOR_W_DEF-1:0] g;
      logic [COLOR_W_DEF-1:0] b;
   } rgb_t;

   // Inactive levels of the active-low syncs and of blank_n during reset
   localparam logic SYNC_IDLE  = 1'b1;
   localparam logic BLANK_IDLE = 1'b0;

endpackage

// File: rtl/vga_layer_compositor_if.sv
// Pixel-side bus of the compositor: timing, layer colours, game levels and outputs.
interface vga_layer_compositor_if #(
   parameter int unsigned NUM_LAYERS = 4,
   parameter int unsigned COLOR_W    = 8
);
   logic                              pix_en;
   logic                              in_hs;
   logic                              in_vs;
   logic                              in_blank_n;
   logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb;
   logic [NUM_LAYERS-1:0]             layer_valid;
   logic [3*COLOR_W-1:0]              bg_rgb;
   logic [3*COLOR_W-1:0]              start_rgb;
   logic [3*COLOR_W-1:0]              over_rgb;
   logic                              game_active;
   logic                              game_over;
   logic [COLOR_W-1:0]                out_r;
   logic [COLOR_W-1:0]                out_g;
   logic [COLOR_W-1:0]                out_b;
   logic                              out_hs;
   logic                              out_vs;
   logic                              out_blank_n;
   logic [1:0]                        phase;
   logic                              blink_on;

   modport master (
      output pix_en, in_hs, in_vs, in_blank_n, layer_rgb, layer_valid,
             bg_rgb, start_rgb, over_rgb, game_active, game_over,
      input  out_r, out_g, out_b, out_hs, out_vs, out_blank_n, phase, blink_on
   );

   modport slave (
      input  pix_en, in_hs, in_vs, in_blank_n, layer_rgb, layer_valid,
             bg_rgb, start_rgb, over_rgb, game_active, game_over,
      output out_r, out_g, out_b, out_hs, out_vs, out_blank_n, phase, blink_on
   );

endinterface

// File: rtl/pix_delay_line.sv
// Pixel-strobe gated shift register with synchronous active-low clear.
module pix_delay_line #(
   parameter int unsigned      WIDTH   = 1,
   parameter int unsigned      DEPTH   = 2,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic             CLOCK_50,
   input  logic             clr_n,
   input  logic             pix_en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   // Shift one position per pixel strobe; clear wins regardless of strobe
   always_ff @(posedge CLOCK_50) begin
      if (!clr_n) begin
         for (int i = 0; i < int'(DEPTH); i++) stage[i] <= CLR_VAL;
      end else if (pix_en) begin
         stage[0] <= d;
         for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_layer_compositor.sv
// Merges sprite layers, background and start/game-over screens into one VGA stream
// with a frame-synchronous game-phase FSM and a blinking game-over overlay.
module vga_layer_compositor
   import vga_comp_pkg::*;
#(
   parameter int unsigned NUM_LAYERS   = 4,
   parameter int unsigned COLOR_W      = COLOR_W_DEF,
   parameter int unsigned PIPE_DEPTH   = 2,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input logic                   CLOCK_50,
   input logic                   reset_n,
   vga_layer_compositor_if.slave bus
);

   localparam int unsigned RGB_W = 3 * COLOR_W;
   localparam int unsigned CNT_W = 8;

   localparam logic [1:0] ST_IDLE = 2'(IDLE);
   localparam logic [1:0] ST_PLAY = 2'(PLAY);
   localparam logic [1:0] ST_OVER = 2'(OVER);

   logic [1:0]       phase_q, phase_d;
   logic             blink_q, blink_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             vs_prev_q;
   logic             frame_tick_c;
   logic [RGB_W-1:0] play_rgb_c;
   logic [RGB_W-1:0] sel_rgb_c;
   logic [RGB_W-1:0] rgb_q;
   logic [2:0]       sync_q;

   // VS falling edge seen on a pixel strobe; reset leaves prev low so a low VS is no tick
   assign frame_tick_c = bus.pix_en & vs_prev_q & ~bus.in_vs;

   // FSM, blink state and VS history registers
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         phase_q   <= ST_IDLE;
         blink_q   <= 1'b0;
         cnt_q     <= '0;
         vs_prev_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         blink_q <= blink_d;
         cnt_q   <= cnt_d;
         if (bus.pix_en) vs_prev_q <= bus.in_vs;
      end
   end

   // Next phase and blink timing, evaluated only on frame ticks
   always_comb begin
      phase_d = phase_q;
      blink_d = blink_q;
      cnt_d   = cnt_q;
      if (frame_tick_c) begin
         case (phase_q)
            ST_IDLE: if (bus.game_active) phase_d = ST_PLAY;
            ST_PLAY: begin
               if (!bus.game_active)   phase_d = ST_IDLE;
               else if (bus.game_over) phase_d = ST_OVER;
            end
            ST_OVER: if (!bus.game_active) phase_d = ST_IDLE;
            default: phase_d = ST_IDLE;
         endcase
         if (phase_d != ST_OVER) begin
            blink_d = 1'b0;
            cnt_d   = '0;
         end else if (phase_q != ST_OVER) begin
            blink_d = 1'b1;
            cnt_d   = '0;
         end else if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_d = ~blink_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Priority encoder: walk from the lowest priority up so layer 0 overrides all
   always_comb begin
      play_rgb_c = bus.bg_rgb;
      for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
         if (bus.layer_valid[i]) play_rgb_c = bus.layer_rgb[i*RGB_W +: RGB_W];
      end
   end

   // Screen select by phase; blanked pixels are black (blank_n travels alongside)
   always_comb begin
      sel_rgb_c = play_rgb_c;
      if (phase_q == ST_IDLE)                  sel_rgb_c = bus.start_rgb;
      else if (phase_q == ST_OVER && blink_q)  sel_rgb_c = bus.over_rgb;
      if (!bus.in_blank_n)                     sel_rgb_c = '0;
   end

   pix_delay_line #(
      .WIDTH   (3),
      .DEPTH   (PIPE_DEPTH),
      .CLR_VAL ({SYNC_IDLE, SYNC_IDLE, BLANK_IDLE})
   ) u_sync_dly (
      .CLOCK_50 (CLOCK_50),
      .clr_n    (reset_n),
      .pix_en   (bus.pix_en),
      .d        ({bus.in_hs, bus.in_vs, bus.in_blank_n}),
      .q        (sync_q)
   );

   pix_delay_line #(
      .WIDTH   (RGB_W),
      .DEPTH   (PIPE_DEPTH),
      .CLR_VAL ('0)
   ) u_rgb_dly (
      .CLOCK_50 (CLOCK_50),
      .clr_n    (reset_n),
      .pix_en   (bus.pix_en),
      .d        (sel_rgb_c),
      .q        (rgb_q)
   );

   assign bus.out_hs      = sync_q[2];
   assign bus.out_vs      = sync_q[1];
   assign bus.out_blank_n = sync_q[0];
   assign bus.out_r       = rgb_q[RGB_W-1 -: COLOR_W];
   assign bus.out_g       = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign bus.out_b       = rgb_q[COLOR_W-1:0];
   assign bus.phase       = phase_q;
   assign bus.blink_on    = blink_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Self-checking bench for vga_layer_compositor: frame-level model plus directed checks.
module tb_vga_layer_compositor;
   import vga_comp_pkg::*;

   localparam int unsigned PD = 2;
   localparam int unsigned BF = 2;

   localparam logic [23:0] L0  = 24'h0000FF;
   localparam logic [23:0] L1  = 24'h00FF00;
   localparam logic [23:0] L2  = 24'hFF0000;
   localparam logic [23:0] L3  = 24'h808080;
   localparam logic [23:0] BG  = 24'h102030;
   localparam logic [23:0] STR = 24'h445566;
   localparam logic [23:0] OVR = 24'hAA00AA;

   localparam logic        EXP_BLINK [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam logic [23:0] EXP_RGB   [5] = '{OVR, OVR, L2, L2, OVR};

   typedef struct packed {
      logic hs;
      logic vs;
      logic bn;
      rgb_t rgb;
   } pix_t;

   logic CLOCK_50;
   logic reset_n;
   logic cmp_en;
   int   checks;
   int   errors;

   vga_layer_compositor_if #(.NUM_LAYERS(4), .COLOR_W(8)) bus ();

   vga_layer_compositor #(
      .NUM_LAYERS   (4),
      .COLOR_W      (8),
      .PIPE_DEPTH   (PD),
      .BLINK_FRAMES (BF)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // ---------------- behavioural model ----------------
   pix_t       m_pipe [$];
   logic [1:0] m_phase;
   logic [1:0] m_old;
   int         m_k;
   logic       m_vs_prev;
   logic       m_blink;
   logic       m_tick;
   pix_t       m_pix;

   function automatic logic [23:0] pick_color(input logic [1:0] ph, input logic bl);
      logic [23:0] c;
      if (ph == 2'(IDLE)) return bus.start_rgb;
      if (ph == 2'(OVER) && bl) return bus.over_rgb;
      for (int i = 0; i < 4; i++) begin
         if (bus.layer_valid[i]) begin
            c = bus.layer_rgb[i*24 +: 24];
            return c;
         end
      end
      return bus.bg_rgb;
   endfunction

   always @(posedge CLOCK_50) begin
      if (!reset_n) begin
         m_phase   = 2'(IDLE);
         m_k       = 0;
         m_vs_prev = 1'b0;
         m_pipe.delete();
         for (int i = 0; i < int'(PD); i++) m_pipe.push_back({1'b1, 1'b1, 1'b0, 24'h0});
      end else if (bus.pix_en) begin
         m_pix.hs  = bus.in_hs;
         m_pix.vs  = bus.in_vs;
         m_pix.bn  = bus.in_blank_n;
         m_pix.rgb = bus.in_blank_n ? pick_color(m_phase, m_blink) : 24'h0;
         m_pipe.push_back(m_pix);
         void'(m_pipe.pop_front());
         m_tick    = m_vs_prev && !bus.in_vs;
         m_vs_prev = bus.in_vs;
         if (m_tick) begin
            m_old = m_phase;
            if (!bus.game_active)                         m_phase = 2'(IDLE);
            else if (m_old == 2'(PLAY) && bus.game_over)  m_phase = 2'(OVER);
            else if (m_old == 2'(IDLE))                   m_phase = 2'(PLAY);
            if (m_phase == 2'(OVER)) m_k = (m_old == 2'(OVER)) ? m_k + 1 : 0;
         end
      end
      m_blink = (m_phase == 2'(OVER)) && (((m_k / int'(BF)) % 2) == 0);
   end

   function automatic logic [29:0] snap();
      return {bus.out_hs, bus.out_vs, bus.out_blank_n,
              bus.out_r, bus.out_g, bus.out_b, bus.phase, bus.blink_on};
   endfunction

   function automatic logic [23:0] out_rgb();
      return {bus.out_r, bus.out_g, bus.out_b};
   endfunction

   // Every-cycle comparison of all outputs against the model
   always @(negedge CLOCK_50) begin
      logic [29:0] exp_w;
      if (cmp_en) begin
         exp_w = {m_pipe[0].hs, m_pipe[0].vs, m_pipe[0].bn, m_pipe[0].rgb, m_phase, m_blink};
         checks++;
         if (snap() !== exp_w) begin
            errors++;
            $display("FAIL model_cmp @%0t: dut=%h expected=%h", $time, snap(), exp_w);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One pixel: strobe cycle followed by an idle cycle
   task automatic pix(input logic hs, input logic vs, input logic bn);
      bus.in_hs      = hs;
      bus.in_vs      = vs;
      bus.in_blank_n = bn;
      bus.pix_en     = 1'b1;
      @(posedge CLOCK_50); #1;
      bus.pix_en     = 1'b0;
      @(posedge CLOCK_50); #1;
   endtask

   // Tiny frame: tick pixel first, ends with VS high so the next frame ticks again
   task automatic frame();
      pix(1'b1, 1'b0, 1'b1);
      pix(1'b1, 1'b0, 1'b0);
      pix(1'b0, 1'b1, 1'b1);
      pix(1'b1, 1'b1, 1'b1);
      pix(1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      cmp_en          = 1'b0;
      reset_n         = 1'b0;
      bus.pix_en      = 1'b0;
      bus.in_hs       = 1'b1;
      bus.in_vs       = 1'b1;
      bus.in_blank_n  = 1'b0;
      bus.layer_rgb   = {L3, L2, L1, L0};
      bus.layer_valid = 4'b0000;
      bus.bg_rgb      = BG;
      bus.start_rgb   = STR;
      bus.over_rgb    = OVR;
      bus.game_active = 1'b0;
      bus.game_over   = 1'b0;

      repeat (2) @(posedge CLOCK_50);
      #1;
      cmp_en = 1'b1;

      // Reset dominates active strobes
      pix(1'b0, 1'b1, 1'b1);
      pix(1'b0, 1'b1, 1'b1);
      chk("reset_state", 32'(snap()), 32'({3'b110, 24'h0, 2'd0, 1'b0}));

      // Release: first pixel needs two strobes to emerge
      reset_n = 1'b1;
      pix(1'b0, 1'b1, 1'b1);
      chk("latency_hold", 32'(snap()), 32'({3'b110, 24'h0, 2'd0, 1'b0}));
      pix(1'b1, 1'b1, 1'b1);
      chk("latency_first", 32'(snap()), 32'({3'b011, STR, 2'd0, 1'b0}));
      pix(1'b1, 1'b1, 1'b1);

      // game_active mid-frame waits for the VS falling strobe
      bus.game_active = 1'b1;
      pix(1'b1, 1'b1, 1'b1);
      pix(1'b1, 1'b1, 1'b1);
      chk("gate_idle", 32'(bus.phase), 32'(IDLE));
      pix(1'b1, 1'b0, 1'b1);
      chk("gate_play", 32'(bus.phase), 32'(PLAY));
      pix(1'b1, 1'b0, 1'b1);
      chk("gate_tick_pixel", 32'(out_rgb()), 32'(STR));
      pix(1'b1, 1'b1, 1'b1);
      chk("gate_next_pixel", 32'(out_rgb()), 32'(BG));

      // Priority
      bus.layer_valid = 4'b0110;
      pix(1'b1, 1'b1, 1'b1);
      pix(1'b1, 1'b1, 1'b1);
      chk("prio_0110", 32'(out_rgb()), 32'(L1));
      bus.layer_valid = 4'b0000;
      pix(1'b1, 1'b1, 1'b1);
      pix(1'b1, 1'b1, 1'b1);
      chk("prio_none", 32'(out_rgb()), 32'(BG));
      bus.layer_valid = 4'b1000;
      pix(1'b1, 1'b1, 1'b1);
      pix(1'b1, 1'b1, 1'b1);
      chk("prio_1000", 32'(out_rgb()), 32'(L3));

      // Blanking forces black, aligned with out_blank_n
      bus.layer_valid = 4'b1111;
      pix(1'b1, 1'b1, 1'b1);
      pix(1'b0, 1'b1, 1'b0);
      chk("blank_pre", 32'({bus.out_blank_n, out_rgb()}), 32'({1'b1, L0}));
      pix(1'b1, 1'b1, 1'b1);
      chk("blank_px", 32'({bus.out_hs, bus.out_blank_n, out_rgb()}), 32'({1'b0, 1'b0, 24'h0}));
      pix(1'b1, 1'b1, 1'b1);
      chk("blank_post", 32'({bus.out_blank_n, out_rgb()}), 32'({1'b1, L0}));

      // Game over blink
      bus.layer_valid = 4'b0100;
      bus.game_over   = 1'b1;
      for (int f = 0; f < 5; f++) begin
         frame();
         chk($sformatf("blink_f%0d", f), 32'(bus.blink_on), 32'(EXP_BLINK[f]));
         chk($sformatf("blink_rgb_f%0d", f), 32'(out_rgb()), 32'(EXP_RGB[f]));
      end
      chk("over_phase", 32'(bus.phase), 32'(OVER));
      bus.game_over = 1'b0;
      frame();
      chk("over_stays", 32'(bus.phase), 32'(OVER));
      bus.game_active = 1'b0;
      frame();
      chk("over_exit", 32'({bus.phase, bus.blink_on}), 32'({2'(IDLE), 1'b0}));

      // Simultaneous drop of game_active and rise of game_over: IDLE wins
      bus.game_active = 1'b1;
      frame();
      chk("sim_play", 32'(bus.phase), 32'(PLAY));
      bus.game_active = 1'b0;
      bus.game_over   = 1'b1;
      frame();
      chk("sim_idle", 32'({bus.phase, bus.blink_on}), 32'({2'(IDLE), 1'b0}));
      frame();
      chk("idle_ignores_over", 32'(bus.phase), 32'(IDLE));

      // Reset mid-frame with VS low at release
      bus.game_over   = 1'b0;
      bus.game_active = 1'b1;
      frame();
      chk("pre_reset_play", 32'(bus.phase), 32'(PLAY));
      reset_n = 1'b0;
      pix(1'b0, 1'b0, 1'b1);
      chk("midframe_reset", 32'(snap()), 32'({3'b110, 24'h0, 2'd0, 1'b0}));
      reset_n = 1'b1;
      pix(1'b1, 1'b0, 1'b1);
      pix(1'b1, 1'b0, 1'b1);
      pix(1'b1, 1'b0, 1'b1);
      chk("no_tick_vs_low", 32'(bus.phase), 32'(IDLE));
      pix(1'b1, 1'b1, 1'b1);
      pix(1'b1, 1'b0, 1'b1);
      chk("fresh_tick", 32'(bus.phase), 32'(PLAY));
      pix(1'b1, 1'b1, 1'b1);
      pix(1'b1, 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_layer_compositor.md
# vga_layer_compositor

Pixel compositor that merges a parametrised number of sprite layers, a background, and start and game-over screens into one VGA RGB stream. It sits between the `vga_time_generator` / sprite generators and the board `VGA_*` pins. It adds a frame-synchronous game-phase state machine, a blinking game-over overlay, and a pipeline that keeps HS, VS and BLANK aligned with colour.

## Interface
- `NUM_LAYERS`, 4: sprite layers; layer 0 has highest priority.
- `COLOR_W`, 8: bits per colour channel.
- `PIPE_DEPTH`, 2: pixel-strobe latency; legal values are 1..4.
- `BLINK_FRAMES`, 30: frames per blink half-period in OVER; legal values are 1..255.

- `CLOCK_50` input, 1: sole clock.
- `reset_n` input, 1: synchronous, active-low reset.
- `pix_en` input, 1: pixel strobe, one `CLOCK_50` cycle per pixel (VGA_CLK rate).
- `in_hs`, `in_vs`, `in_blank_n` input, 1 each: timing from the generator; HS and VS are active-low.
- `layer_rgb` input, `NUM_LAYERS*3*COLOR_W`: packed {R,G,B} per layer; layer i is at slice i.
- `layer_valid` input, `NUM_LAYERS`: per-layer opacity.
- `bg_rgb`, `start_rgb`, `over_rgb` input, `3*COLOR_W` each: map, start screen and game-over screen colours.
- `game_active`, `game_over` input, 1 each: level signals from game logic.
- `out_r`, `out_g`, `out_b` output, `COLOR_W` each: composited colour.
- `out_hs`, `out_vs`, `out_blank_n` output, 1 each: delayed timing.
- `phase` output, 2: current FSM state.
- `blink_on` output, 1: the game-over overlay is currently shown.

## Operation
- FSM states: IDLE=0, PLAY=1, OVER=2.
- A frame tick is the `pix_en` cycle where `in_vs` goes from 1 to 0. State changes happen only on a frame tick, using `game_active` / `game_over` sampled on that cycle.
- IDLE goes to PLAY if `game_active`=1. `game_over` is ignored in IDLE.
- PLAY goes to IDLE if `game_active`=0. Otherwise it goes to OVER if `game_over`=1. If both conditions hold, IDLE wins.
- OVER goes to IDLE if `game_active`=0. `game_over` dropping alone does not leave OVER.
- Blink counter (8 bits) is cleared on entry to OVER and `blink_on` is set to 1 on entry.
  - Each frame tick in OVER increments the counter.
  - When the counter reaches `BLINK_FRAMES`-1, `blink_on` toggles and the counter clears.
  - Outside OVER, `blink_on` is 0.
- Colour select per pixel:
  - IDLE: `start_rgb`.
  - OVER with `blink_on`=1: `over_rgb`.
  - PLAY, or OVER with `blink_on`=0: the lowest-index layer with `layer_valid` set, else `bg_rgb`.
- If the delayed `in_blank_n`=0, the output colour is forced to 0.
- Width rule: `layer_rgb` slice i is bits `[(i+1)*3*COLOR_W-1 : i*3*COLOR_W]`, with R in the MSBs.

## Timing
- All pipeline registers advance only when `pix_en`=1. When `pix_en`=0, every output holds its value.
- Latency: an input sampled on pix strobe n appears on outputs after pix strobe n+`PIPE_DEPTH`-1's register update, i.e. exactly `PIPE_DEPTH` strobes. `out_hs`, `out_vs`, `out_blank_n` and the colour outputs share this latency exactly.
- The state and colour-select decision are registered in stage 1. A state change on a frame tick therefore affects the pixel that accompanies the frame tick's successor.
- Reset values, held while `reset_n`=0 on any edge regardless of `pix_en`:
  - `out_r`, `out_g`, `out_b` = 0.
  - `out_hs` = 1, `out_vs` = 1, `out_blank_n` = 0.
  - `phase` = IDLE, `blink_on` = 0.
  - Pipeline contents cleared to the same values; blink counter = 0.
- Reset asserted mid-frame: outputs go to reset values on the next edge. After release, the FSM waits for a fresh frame tick. A VS already low at release does not count as a tick.

## Structure
- Package `vga_comp_pkg`:
  - `phase_t` enum (IDLE, PLAY, OVER).
  - `rgb_t` struct, parameterised by `COLOR_W` via a localparam default of 8.
  - Timing-polarity constants: `SYNC_IDLE`=1, `BLANK_IDLE`=0.
- Sub-module `pix_delay_line`: a `pix_en`-gated shift register with a synchronous active-low clear.
  - Parameters are WIDTH and DEPTH.
  - One instance each carries {hs, vs, blank_n} and the selected colour.
- The priority encoder is a combinational loop in the top module.

## Test plan
- Reset then release, with `pix_en` toggling every other cycle:
  - Outputs stay at 0 / hs=1 / vs=1 / blank_n=0 until the first valid data has propagated.
  - The first valid data appears exactly 2 strobes after release (`PIPE_DEPTH`=2).
- Priority in PLAY with `layer_valid`=4'b0110, layer1 = 0x00FF00 and layer2 = 0xFF0000: output 0x00FF00. With `layer_valid`=0: output `bg_rgb`.
- Frame-tick gating: `game_active` rises mid-frame.
  - `phase` stays IDLE until the next VS falling strobe, then becomes PLAY.
  - Output switches from `start_rgb` to the play-field on the following pixel.
- Game-over blink with `BLINK_FRAMES`=2:
  - Enter OVER: `blink_on` reads 1,1,0,0,1 across five consecutive frame ticks.
  - Output alternates between `over_rgb` and the play-field.
- Simultaneous event in PLAY: `game_active`=0 and `game_over`=1 on the same tick gives `phase`=IDLE, and OVER is never entered.
- Blanking with `in_blank_n`=0 and `layer_valid` all ones: RGB output is 0, delayed by `PIPE_DEPTH` strobes, with `out_blank_n` aligned to it.
